// File: rtl/clk_div_pkg.sv
// clk_div_pkg: FSM states, debounce length and half-period clamp for clk_div_gen.
// DEBOUNCE_CYCLES is only used when CLKDIV_DEBOUNCE_EN is defined.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_HI,
    STEP_LO
  } state_t;

  localparam logic [19:0] DEBOUNCE_CYCLES = 20'd500000;

  function automatic logic [31:0] clamp_half(input logic [31:0] hp);
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: step-button synchroniser and rising-edge pulse generator.
// Define CLKDIV_DEBOUNCE_EN to insert a debouncer after the synchroniser.
module btn_sync_edge
  import clk_div_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
  end

`ifdef CLKDIV_DEBOUNCE_EN
  logic [19:0] db_cnt_q;
  logic        db_q;

  // Level follows the input only after it has held steady long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
      db_cnt_q <= '0;
      db_q     <= sync_q[SYNC_STAGES-1];
    end else begin
      db_cnt_q <= db_cnt_q + 20'd1;
    end
  end

  assign lvl = db_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign pulse = lvl & ~prev_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock divider with enable and single-step mode.
// Optional step debouncer via CLKDIV_DEBOUNCE_EN (see btn_sync_edge).
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int DEFAULT_HALF = 2500000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] half_period,
  input  logic             step_req,
  output logic             clk_out,
  output logic             tick,
  output logic             step_busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] hp_in;
  logic             clk_q, clk_d;
  logic             busy_q, busy_d;
  logic             mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             step_pulse;
  logic             term;
  logic             bound;
  logic             mode_eff;

  btn_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (step_req),
    .pulse(step_pulse)
  );

  assign hp_in    = CNT_W'(clamp_half(32'(half_period)));
  assign term     = (cnt_q == hp_q - CNT_W'(1));
  assign bound    = !clk_q && (cnt_q == '0);
  // At a period boundary the live mode decides, so no period is cut short.
  assign mode_eff = bound ? mode : mode_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    clk_d   = clk_q;
    busy_d  = busy_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    if (bound) mode_d = mode;
    if (enable) begin
      tick_d = pend_q;
      pend_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        hp_d = hp_in;
        if (!mode_eff) begin
          state_d = RUN;
        end else if (enable && step_pulse) begin
          state_d = STEP_HI;
          clk_d   = 1'b1;
          busy_d  = 1'b1;
          pend_d  = 1'b1;
        end
      end
      RUN: begin
        if (mode_eff) begin
          state_d = IDLE;
        end else if (enable) begin
          if (term) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            hp_d   = hp_in;
            pend_d = ~clk_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STEP_HI: begin
        if (enable) begin
          if (term) begin
            cnt_d   = '0;
            clk_d   = 1'b0;
            hp_d    = hp_in;
            state_d = STEP_LO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STEP_LO: begin
        if (enable) begin
          if (term) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            hp_d    = hp_in;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hp_q    <= CNT_W'(DEFAULT_HALF);
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= 1'b0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign step_busy = busy_q;

endmodule
